// File: rtl/nanolada_pkg.sv
// rtl/nanolada_pkg.sv - nanoLADA opcodes, sequencer state encoding and datapath select codes
package nanolada_pkg;

  localparam logic [5:0] OP_ALU  = 6'b000001;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_ORUI = 6'b010001;
  localparam logic [5:0] OP_LW   = 6'b011000;
  localparam logic [5:0] OP_SW   = 6'b011100;
  localparam logic [5:0] OP_BEQ  = 6'b100100;
  localparam logic [5:0] OP_JMP  = 6'b110000;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;

  // Datapath selects that stay constant for the whole instruction
  typedef struct packed {
    logic       sel_wr;
    logic       sel_b;
    logic       sel_data;
    logic [1:0] ext_ops;
    logic [2:0] alu_ops;
  } sel_t;

endpackage

// File: rtl/nanolada_decode.sv
// rtl/nanolada_decode.sv - opcode/func to datapath select vector plus legal-opcode flag
module nanolada_decode
  import nanolada_pkg::*;
(
  input  logic [5:0] op,
  input  logic [2:0] func,
  output sel_t       sel,
  output logic       legal
);

  always_comb begin
    sel   = '0;
    legal = 1'b1;
    case (op)
      OP_ORI: begin
        sel.sel_wr  = 1'b1;
        sel.sel_b   = 1'b1;
        sel.ext_ops = EXT_ZERO;
        sel.alu_ops = ALU_OR;
      end
      OP_ORUI: begin
        sel.sel_wr  = 1'b1;
        sel.sel_b   = 1'b1;
        sel.ext_ops = EXT_UPPER;
        sel.alu_ops = ALU_OR;
      end
      OP_ALU: begin
        sel.alu_ops = func;
      end
      OP_LW: begin
        sel.sel_wr   = 1'b1;
        sel.sel_b    = 1'b1;
        sel.sel_data = 1'b1;
        sel.ext_ops  = EXT_SIGN;
        sel.alu_ops  = ALU_NOP;
      end
      OP_SW: begin
        sel.sel_b   = 1'b1;
        sel.ext_ops = EXT_SIGN;
        sel.alu_ops = ALU_NOP;
      end
      OP_BEQ: begin
        sel.ext_ops = EXT_SIGN;
        sel.alu_ops = ALU_SUB;
      end
      OP_JMP: begin
        sel.alu_ops = ALU_NOP;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - nanoLADA multi-cycle control FSM over one shared memory port
// Optional NANOLADA_PERF_CNT_EN: live cycle_cnt/instr_cnt counters (tied to 0 otherwise).
module multicycle_sequencer
  import nanolada_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0,
  parameter int TMO_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [2:0]  func,
  input  logic        z_flag,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel_d,
  output logic        ir_wr,
  output logic        pc_wr,
  output logic        sel_pc,
  output logic        sel_addpc,
  output logic        sel_wr,
  output logic        sel_b,
  output logic        sel_data,
  output logic        reg_wr,
  output logic [1:0]  ext_ops,
  output logic [2:0]  alu_ops,
  output logic        illegal,
  output logic        bus_err,
  output logic [2:0]  state_o,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t           state, state_nx;
  logic [5:0]       op_q;
  logic [2:0]       func_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic             set_illegal, set_bus_err;

  logic [5:0] dec_op;
  logic [2:0] dec_func;
  sel_t       dec_sel;
  logic       dec_legal;
  logic       in_instr;
  logic       waiting;
  logic       tmo_hit;

  // In DECODE the IR is read directly so selects are valid in the same cycle
  assign dec_op   = (state == ST_DECODE) ? opcode : op_q;
  assign dec_func = (state == ST_DECODE) ? func   : func_q;

  nanolada_decode u_decode (
    .op    (dec_op),
    .func  (dec_func),
    .sel   (dec_sel),
    .legal (dec_legal)
  );

  assign in_instr = state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB};
  assign waiting  = (state inside {ST_FETCH, ST_MEM}) && !mem_ack;
  assign tmo_hit  = (MEM_TIMEOUT != 0) && waiting && (tmo_cnt == TMO_LAST);

  assign sel_wr   = in_instr & dec_sel.sel_wr;
  assign sel_b    = in_instr & dec_sel.sel_b;
  assign sel_data = in_instr & dec_sel.sel_data;
  assign ext_ops  = in_instr ? dec_sel.ext_ops : 2'b00;
  assign alu_ops  = in_instr ? dec_sel.alu_ops : 3'b000;
  assign state_o  = state;

  always_comb begin
    state_nx    = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_sel_d   = 1'b0;
    ir_wr       = 1'b0;
    pc_wr       = 1'b0;
    sel_pc      = 1'b0;
    sel_addpc   = 1'b0;
    reg_wr      = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    case (state)
      ST_INIT: state_nx = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_wr    = 1'b1;
          pc_wr    = 1'b1;
          state_nx = ST_DECODE;
        end else if (tmo_hit) begin
          set_bus_err = 1'b1;
          state_nx    = ST_TRAP;
        end
      end
      ST_DECODE: begin
        if (!dec_legal) begin
          set_illegal = 1'b1;
          state_nx    = ST_TRAP;
        end else if (opcode == OP_JMP) begin
          pc_wr    = 1'b1;
          sel_pc   = 1'b1;
          state_nx = ST_FETCH;
        end else begin
          state_nx = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_BEQ: begin
            pc_wr     = z_flag;
            sel_addpc = 1'b1;
            state_nx  = ST_FETCH;
          end
          OP_LW, OP_SW: state_nx = ST_MEM;
          default:      state_nx = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        mem_sel_d = 1'b1;
        mem_we    = (op_q == OP_SW);
        if (mem_ack) begin
          state_nx = (op_q == OP_SW) ? ST_FETCH : ST_WB;
        end else if (tmo_hit) begin
          set_bus_err = 1'b1;
          state_nx    = ST_TRAP;
        end
      end
      ST_WB: begin
        reg_wr   = 1'b1;
        state_nx = ST_FETCH;
      end
      ST_TRAP: state_nx = ST_TRAP;
      default: state_nx = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_INIT;
      op_q    <= '0;
      func_q  <= '0;
      tmo_cnt <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_DECODE) begin
        op_q   <= opcode;
        func_q <= func;
      end
      // Any cycle that is not a stalled transfer restarts the wait count
      if (waiting && (MEM_TIMEOUT != 0)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
      if (set_illegal) illegal <= 1'b1;
      if (set_bus_err) bus_err <= 1'b1;
    end
  end

`ifdef NANOLADA_PERF_CNT_EN
  logic [31:0] cycle_q, instr_q;
  logic        instr_done;

  assign instr_done = in_instr && (state_nx == ST_FETCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (state != ST_INIT && state != ST_TRAP) cycle_q <= cycle_q + 32'd1;
      if (instr_done)                           instr_q <= instr_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - randomized trace-model bench for multicycle_sequencer
module tb_multicycle_sequencer;

  localparam int TMO = 4;
  localparam logic [5:0] T_ALU = 6'b000001, T_ORI = 6'b010000, T_ORUI = 6'b010001;
  localparam logic [5:0] T_LW = 6'b011000, T_SW = 6'b011100, T_BEQ = 6'b100100, T_JMP = 6'b110000;

  typedef struct packed {
    logic [2:0] st;
    logic req, we, seld, irw, pcw, spc, sadd, swr, sb, sdata, rwr;
    logic [1:0] ext;
    logic [2:0] alu;
    logic ill, berr;
  } ov_t;

  typedef struct {
    ov_t  v;
    logic ack;
    logic last;
  } cyc_t;

  logic clk = 1'b0, reset = 1'b1, z_flag = 1'b0, mem_ack = 1'b0;
  logic [5:0] opcode = '0;
  logic [2:0] func = '0;
  logic mem_req, mem_we, mem_sel_d, ir_wr, pc_wr, sel_pc, sel_addpc;
  logic sel_wr, sel_b, sel_data, reg_wr, illegal, bus_err;
  logic [1:0] ext_ops;
  logic [2:0] alu_ops, state_o;
  logic [31:0] cycle_cnt, instr_cnt;

  multicycle_sequencer #(.MEM_TIMEOUT(TMO), .TMO_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .z_flag(z_flag),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_sel_d(mem_sel_d),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .sel_pc(sel_pc), .sel_addpc(sel_addpc),
    .sel_wr(sel_wr), .sel_b(sel_b), .sel_data(sel_data), .reg_wr(reg_wr),
    .ext_ops(ext_ops), .alu_ops(alu_ops), .illegal(illegal), .bus_err(bus_err),
    .state_o(state_o), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  cyc_t q[$];
  logic exp_ill = 1'b0, exp_berr = 1'b0;
  int unsigned exp_cyc = 0, exp_ins = 0;
  logic [5:0] cur_op;
  logic [2:0] cur_func;
  logic cur_z;
  string cur_tag;
  logic [5:0] legal_ops [7] = '{T_ALU, T_ORI, T_ORUI, T_LW, T_SW, T_BEQ, T_JMP};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ov_t obs();
    return {state_o, mem_req, mem_we, mem_sel_d, ir_wr, pc_wr, sel_pc, sel_addpc,
            sel_wr, sel_b, sel_data, reg_wr, ext_ops, alu_ops, illegal, bus_err};
  endfunction

  function automatic logic legal_op(input logic [5:0] op);
    return op inside {T_ALU, T_ORI, T_ORUI, T_LW, T_SW, T_BEQ, T_JMP};
  endfunction

  // Select table as listed for the instruction set
  function automatic ov_t sels(input logic [5:0] op, input logic [2:0] fn);
    ov_t v = '0;
    if (op == T_ORI)  begin v.swr = 1; v.sb = 1; v.alu = 3'b010; end
    if (op == T_ORUI) begin v.swr = 1; v.sb = 1; v.alu = 3'b010; v.ext = 2'b10; end
    if (op == T_ALU)  v.alu = fn;
    if (op == T_LW)   begin v.swr = 1; v.sb = 1; v.sdata = 1; v.ext = 2'b01; end
    if (op == T_SW)   begin v.sb = 1; v.ext = 2'b01; end
    if (op == T_BEQ)  begin v.ext = 2'b01; v.alu = 3'b001; end
    return v;
  endfunction

  task automatic push(input ov_t v, input logic ack, input logic last);
    cyc_t c;
    c.v = v; c.ack = ack; c.last = last;
    q.push_back(c);
  endtask

  task automatic trap(input int n);
    ov_t v;
    for (int i = 0; i < n; i++) begin
      v = '0; v.st = 3'd6; v.ill = exp_ill; v.berr = exp_berr;
      push(v, 1'b0, 1'b0);
    end
  endtask

  // Expected per-cycle trace of one instruction; md < 0 means memory never acks
  task automatic build(input logic [5:0] op, input logic [2:0] fn, input logic z,
                       input int fd, input int md);
    ov_t s, v;
    s = sels(op, fn); s.ill = exp_ill; s.berr = exp_berr;
    for (int i = 0; i <= fd; i++) begin
      v = '0; v.st = 3'd1; v.req = 1; v.irw = (i == fd); v.pcw = (i == fd);
      v.ill = exp_ill; v.berr = exp_berr;
      push(v, i == fd, 1'b0);
    end
    v = s; v.st = 3'd2;
    if (!legal_op(op)) begin
      push(v, 1'b0, 1'b0); exp_ill = 1'b1; trap(20); return;
    end
    if (op == T_JMP) begin
      v.pcw = 1; v.spc = 1; push(v, 1'b0, 1'b1); return;
    end
    push(v, 1'b0, 1'b0);
    v = s; v.st = 3'd3;
    if (op == T_BEQ) begin
      v.pcw = z; v.sadd = 1; push(v, 1'b0, 1'b1); return;
    end
    push(v, 1'b0, 1'b0);
    if (op == T_LW || op == T_SW) begin
      v = s; v.st = 3'd4; v.req = 1; v.seld = 1; v.we = (op == T_SW);
      if (md < 0) begin
        for (int i = 0; i < TMO; i++) push(v, 1'b0, 1'b0);
        exp_berr = 1'b1; trap(5); return;
      end
      for (int i = 0; i <= md; i++) push(v, i == md, (i == md) && (op == T_SW));
      if (op == T_SW) return;
    end
    v = s; v.st = 3'd5; v.rwr = 1; push(v, 1'b0, 1'b1);
  endtask

  task automatic apply_n(input int n);
    cyc_t r;
    for (int k = 0; k < n && q.size() > 0; k++) begin
      r = q.pop_front();
      opcode  = (r.v.st == 3'd2) ? cur_op : 6'($urandom);
      func    = (r.v.st == 3'd2) ? cur_func : 3'($urandom);
      z_flag  = (r.v.st == 3'd3) ? cur_z : 1'($urandom);
      mem_ack = (r.v.st == 3'd1 || r.v.st == 3'd4) ? r.ack : 1'($urandom);
      @(negedge clk);
      check($sformatf("%s st%0d", cur_tag, r.v.st), 32'(obs()), 32'(r.v));
      if (r.v.st != 3'd0 && r.v.st != 3'd6) exp_cyc++;
      if (r.last) exp_ins++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input string tag, input logic [5:0] op, input logic [2:0] fn,
                     input logic z, input int fd, input int md);
    q.delete();
    cur_tag = tag; cur_op = op; cur_func = fn; cur_z = z;
    build(op, fn, z, fd, md);
    apply_n(q.size());
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("in_reset", 32'(obs()), 32'd0);
    check("perf_reset", cycle_cnt | instr_cnt, 32'd0);
    reset = 1'b0;
    exp_ill = 1'b0; exp_berr = 1'b0; exp_cyc = 0; exp_ins = 0;
    mem_ack = 1'($urandom);
    @(negedge clk);
    check("init", 32'(obs()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_perf(input string tag, input int unsigned ins, input int unsigned cyc);
`ifdef NANOLADA_PERF_CNT_EN
    check({tag, " instr_cnt"}, instr_cnt, ins);
    check({tag, " cycle_cnt"}, cycle_cnt, cyc);
`else
    check({tag, " instr_cnt"}, instr_cnt, 32'd0 & ins);
    check({tag, " cycle_cnt"}, cycle_cnt, 32'd0 & cyc);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op;
    do_reset();

    for (int i = 0; i < 10; i++) run("jmp", T_JMP, 3'($urandom), 1'b0, 0, 0);
    check_perf("jmp10", 10, 20);

    run("ori", T_ORI, 3'd5, 1'b0, 0, 0);
    run("lw_wait", T_LW, 3'd0, 1'b0, 0, 2);
    run("beq_z1", T_BEQ, 3'd0, 1'b1, 0, 0);
    run("beq_z0", T_BEQ, 3'd0, 1'b0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 6)];
      run("rand", op, 3'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      if (!legal_op(op)) do_reset();
    end
    check_perf("rand", exp_ins, exp_cyc);

    run("illegal", 6'b111111, 3'd0, 1'b0, 0, 0);
    check("illegal_sticky", 32'(illegal), 32'd1);
    do_reset();

    run("sw_tmo", T_SW, 3'd0, 1'b0, 0, -1);
    check("bus_err_sticky", 32'(bus_err), 32'd1);
    do_reset();

    q.delete();
    cur_tag = "sw_rst"; cur_op = T_SW; cur_func = 3'd0; cur_z = 1'b0;
    build(T_SW, 3'd0, 1'b0, 0, -1);
    apply_n(5);
    mem_ack = 1'b0;
    #2;
    check("pre_rst_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_req_drop", 32'(mem_req), 32'd0);
    check("rst_strobes", 32'({ir_wr, pc_wr, reg_wr, mem_we}), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    q.delete();
    do_reset();
    run("post_rst_ori", T_ORUI, 3'd0, 1'b0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the nanoLADA datapath; replaces single-cycle decode.
- Sequences fetch, decode, execute, memory and write-back over one shared instruction/data memory port with a req/ack handshake.
- Generates PC/IR write strobes plus the standard datapath selects, held stable for the whole instruction.

Parameters:
- MEM_TIMEOUT, 0, cycles to wait for mem_ack before a bus-error trap; 0 disables the timeout.
- TMO_W, 8, width of the timeout counter; MEM_TIMEOUT must be < 2**TMO_W.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  6  IR[31:26]
- func  in  3  IR[2:0], ALU function for R-type
- z_flag  in  1  ALU zero flag
- mem_ack  in  1  memory transfer complete this cycle
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_sel_d  out  1  address source: 0 = PC, 1 = ALU result
- ir_wr  out  1  load IR
- pc_wr  out  1  load PC
- sel_pc, sel_addpc, sel_wr, sel_b, sel_data, reg_wr  out  1 each  datapath selects
- ext_ops  out  2  immediate extend mode
- alu_ops  out  3  ALU operation
- illegal  out  1  sticky illegal-opcode trap
- bus_err  out  1  sticky memory-timeout trap
- state_o  out  3  current state, for debug

Behaviour:
- Opcodes: ORI 010000, ORUI 010001, ALU 000001, LW 011000, SW 011100, BEQ 100100, JMP 110000. Any other opcode is illegal.
- States and encoding: INIT 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, TRAP 6.
- Reset: state = INIT, op_q = 0, func_q = 0, timeout count = 0, illegal = 0, bus_err = 0. All outputs are 0 while in INIT. INIT always goes to FETCH on the next clock.
- FETCH: mem_req = 1, mem_sel_d = 0, mem_we = 0. Hold the state until mem_ack. In the ack cycle: ir_wr = 1 and pc_wr = 1 with sel_pc = 0, sel_addpc = 0 (PC+4); then go to DECODE.
- DECODE: latch op_q = opcode, func_q = func.
  - Illegal opcode: go to TRAP with illegal = 1.
  - JMP: pc_wr = 1, sel_pc = 1; go to FETCH.
  - Otherwise: go to EXEC.
- EXEC:
  - BEQ: pc_wr = z_flag, sel_addpc = 1 (target = PC+4 + offset); go to FETCH.
  - LW, SW: go to MEM.
  - ORI, ORUI, ALU: go to WB.
- MEM: mem_req = 1, mem_sel_d = 1, mem_we = (op_q == SW). Hold until mem_ack. On ack, SW goes to FETCH and LW goes to WB.
- WB: reg_wr = 1 for exactly one cycle; go to FETCH.
- Selects, from DECODE through WB, are a decode of op_q (op_q = opcode in DECODE):
  - sel_wr = ORI | ORUI | LW
  - sel_b = ORI | ORUI | LW | SW
  - sel_data = LW
  - ext_ops: ORUI = 10; LW, SW, BEQ = 01; else 00
  - alu_ops: ORI, ORUI = 010; BEQ = 001; ALU = func_q; else 000
  - In FETCH and INIT all selects are 0.
- Strobes are asserted only in the states listed above and are never asserted otherwise.
- Handshake rules:
  - Once mem_req rises it stays high, with mem_we and mem_sel_d stable, until the ack cycle.
  - mem_ack while mem_req = 0 is ignored.
  - An ack in the same cycle as req (zero-wait) completes the transfer in 1 cycle.
- Timeout (MEM_TIMEOUT > 0): the counter clears on entry to FETCH or MEM and increments each waiting cycle. When it reaches MEM_TIMEOUT without an ack, go to TRAP with bus_err = 1 and drop mem_req.
- TRAP: all strobes 0, mem_req = 0. illegal and bus_err hold until reset.
- Zero-wait latencies (cycles): JMP 2, BEQ 3, SW 4, ORI/ORUI/ALU 4, LW 5.
- Reset mid-transfer: asynchronous return to INIT, mem_req drops immediately, no partial register or PC write occurs.

Optional Feature:
- Macro: NANOLADA_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt[31:0] and instr_cnt[31:0].
  - cycle_cnt increments every cycle outside INIT and TRAP.
  - instr_cnt increments on each transition into FETCH from DECODE, EXEC, MEM or WB.
  - Both clear on reset and wrap at 2^32.
- Undefined: the ports are present and tied to 0; no counter flops exist.

Decomposition:
- Package nanolada_pkg: opcode constants, state encoding, ext_ops and alu_ops codes.
- Sub-module nanolada_decode: combinational op_q/func_q to select vector plus the legal flag. The sequencer instantiates it once.

Test Plan:
- Reset, then ORI with zero-wait ack: states INIT, FETCH, DECODE, EXEC, WB, FETCH. reg_wr high exactly 1 cycle, sel_wr = 1, sel_b = 1, alu_ops = 010.
- LW with 3-cycle ack delay in MEM: mem_req, mem_sel_d = 1 and mem_we = 0 stable for 3 cycles. Then WB with sel_data = 1, reg_wr = 1. Total 7 cycles.
- BEQ twice, z_flag = 1 then z_flag = 0: pc_wr = 1 then 0 in EXEC, sel_addpc = 1, ext_ops = 01, alu_ops = 001. Both return to FETCH.
- Opcode 111111: TRAP after DECODE. illegal = 1, mem_req stays 0 for 20 cycles, cleared only by reset.
- MEM_TIMEOUT = 4, SW with no ack: bus_err = 1 after 4 waiting cycles, mem_req drops. Assert reset mid-MEM in a separate run: mem_req falls asynchronously, no write strobe.
- With NANOLADA_PERF_CNT_EN: run JMP ×10 zero-wait. instr_cnt = 10, cycle_cnt = 20.
